// File: rtl/softmax_stream_p.sv
// softmax_stream_p: row-buffered base-2 integer softmax.
// A row of N beats is buffered while its signed max is tracked; the buffer is
// then swept once to accumulate S = sum(2^(E_W-1) >> (M - x)). A restoring
// divide forms R = floor(2^K / S), and a second sweep emits
// p = min((e * R) >> E_W, 2^OUT_W - 1) per element with ready/valid backpressure.
module softmax_stream_p #(
  parameter int LANES         = 8,
  parameter int IN_W          = 8,
  parameter int OUT_W         = 8,
  parameter int E_W           = 16,
  parameter int MAX_ROW_BEATS = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(MAX_ROW_BEATS):0]    row_beats,
  input  logic [LANES*IN_W-1:0]             input_bar,
  input  logic                              bar_valid,
  output logic                              bar_ready,
  output logic [LANES*OUT_W-1:0]            output_bar,
  output logic                              output_valid,
  input  logic                              output_ready,
  output logic                              output_last,
  output logic                              busy
);

  localparam int N_MAX = LANES * MAX_ROW_BEATS;
  localparam int S_W   = E_W + $clog2(N_MAX);
  localparam int K     = OUT_W + E_W;
  localparam int R_W   = OUT_W + 2;
  localparam int CNT_W = $clog2(MAX_ROW_BEATS) + 1;
  localparam int IDX_W = (MAX_ROW_BEATS > 1) ? $clog2(MAX_ROW_BEATS) : 1;
  localparam int DC_W  = $clog2(K) + 1;
  localparam int D_W   = IN_W + 1;
  localparam int P_W   = E_W + R_W;

  localparam logic [CNT_W-1:0] MAX_N   = CNT_W'(MAX_ROW_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DC_W-1:0]  K_LAST  = DC_W'(K - 1);
  localparam logic [D_W-1:0]   D_LIM   = D_W'(E_W);
  localparam logic [E_W-1:0]   E_ONE   = {1'b1, {(E_W-1){1'b0}}};
  localparam logic [P_W-1:0]   P_MAX   = P_W'((1 << OUT_W) - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SUM, DIV, OUT} state_t;

  // e = 2^(E_W-1) >> (m - x), zero once the shift empties the word
  function automatic logic [E_W-1:0] exp2_e(input logic signed [IN_W-1:0] m,
                                            input logic signed [IN_W-1:0] x);
    logic [D_W-1:0] d;
    d = {m[IN_W-1], m} - {x[IN_W-1], x};
    exp2_e = (d < D_LIM) ? (E_ONE >> d) : '0;
  endfunction

  function automatic logic signed [IN_W-1:0] beat_max(input logic [LANES*IN_W-1:0] v);
    logic signed [IN_W-1:0] mx;
    mx = v[IN_W-1:0];
    for (int unsigned i = 1; i < LANES; i++) begin
      if ($signed(v[i*IN_W +: IN_W]) > mx) mx = v[i*IN_W +: IN_W];
    end
    beat_max = mx;
  endfunction

  function automatic logic [S_W-1:0] beat_sum(input logic signed [IN_W-1:0] m,
                                              input logic [LANES*IN_W-1:0] v);
    logic [S_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      acc = acc + S_W'(exp2_e(m, v[i*IN_W +: IN_W]));
    end
    beat_sum = acc;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] beat_prob(input logic signed [IN_W-1:0] m,
                                                       input logic [LANES*IN_W-1:0] v,
                                                       input logic [R_W-1:0] r);
    logic [P_W-1:0] prod;
    logic [P_W-1:0] shifted;
    logic [LANES*OUT_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod    = P_W'(exp2_e(m, v[i*IN_W +: IN_W])) * P_W'(r);
      shifted = prod >> E_W;
      p[i*OUT_W +: OUT_W] = (shifted > P_MAX) ? '1 : shifted[OUT_W-1:0];
    end
    beat_prob = p;
  endfunction

  state_t                   state_q, state_d;
  logic                     bar_ready_q, bar_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [LANES*OUT_W-1:0]   out_bar_q, out_bar_d;
  logic                     busy_q, busy_d;
  logic [CNT_W-1:0]         n_q, n_d;
  logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic signed [IN_W-1:0]   max_q, max_d;
  logic [S_W-1:0]           sum_q, sum_d;
  logic [S_W-1:0]           rem_q, rem_d;
  logic [R_W-1:0]           quo_q, quo_d;
  logic [DC_W-1:0]          div_cnt_q, div_cnt_d;

  logic [LANES*IN_W-1:0]    row_mem_q [MAX_ROW_BEATS];
  logic                     buf_we;
  logic [IDX_W-1:0]         buf_widx;
  logic [LANES*IN_W-1:0]    rd_data;
  logic signed [IN_W-1:0]   in_max;
  logic [CNT_W-1:0]         row_n;
  logic                     in_hs;
  logic [S_W:0]             rem_sh;
  logic                     div_ge;

  assign rd_data = row_mem_q[rd_cnt_q[IDX_W-1:0]];
  assign in_max  = beat_max(input_bar);
  assign row_n   = (row_beats == '0 || row_beats > MAX_N) ? MAX_N : row_beats;
  assign in_hs   = bar_valid && bar_ready_q;
  assign rem_sh  = {rem_q, 1'b0};
  assign div_ge  = (rem_sh >= {1'b0, sum_q});

  // Next-state and datapath updates for the load/sum/divide/emit sequence
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_bar_d   = out_bar_q;
    n_d         = n_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    max_d       = max_q;
    sum_d       = sum_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_cnt_d   = div_cnt_q;
    buf_we      = 1'b0;
    buf_widx    = wr_cnt_q[IDX_W-1:0];
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          buf_we   = 1'b1;
          buf_widx = '0;
          n_d      = row_n;
          max_d    = in_max;
          sum_d    = '0;
          wr_cnt_d = CNT_ONE;
          rd_cnt_d = '0;
          if (row_n == CNT_ONE) begin
            wr_cnt_d = '0;
            state_d  = SUM;
          end else begin
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_hs) begin
          buf_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if (in_max > max_q) max_d = in_max;
          if (wr_cnt_q == n_q - CNT_ONE) begin
            wr_cnt_d = '0;
            state_d  = SUM;
          end
        end
      end
      SUM: begin
        sum_d    = sum_q + beat_sum(max_q, rd_data);
        rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (rd_cnt_q == n_q - CNT_ONE) begin
          // Quotient bit K is always 0 (S > 1), so the divide starts with
          // that step already taken: remainder 1, K steps left.
          rd_cnt_d  = '0;
          rem_d     = S_W'(1);
          quo_d     = '0;
          div_cnt_d = '0;
          state_d   = DIV;
        end
      end
      DIV: begin
        rem_d     = div_ge ? S_W'(rem_sh - {1'b0, sum_q}) : S_W'(rem_sh);
        quo_d     = (quo_q << 1) | R_W'(div_ge);
        div_cnt_d = div_cnt_q + DC_W'(1);
        if (div_cnt_q == K_LAST) state_d = OUT;
      end
      OUT: begin
        if (!out_valid_q || output_ready) begin
          if (out_valid_q && out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_bar_d   = '0;
            rd_cnt_d    = '0;
            state_d     = IDLE;
          end else begin
            out_bar_d   = beat_prob(max_q, rd_data, quo_q);
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q == n_q - CNT_ONE);
            rd_cnt_d    = rd_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    bar_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d      = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bar_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bar_q   <= '0;
      busy_q      <= 1'b0;
      n_q         <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bar_ready_q <= bar_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_bar_q   <= out_bar_d;
      busy_q      <= busy_d;
      n_q         <= n_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  // Single-bank row buffer; contents need no reset
  always_ff @(posedge clk) begin
    if (buf_we) row_mem_q[buf_widx] <= input_bar;
  end

  assign bar_ready    = bar_ready_q;
  assign output_bar   = out_bar_q;
  assign output_valid = out_valid_q;
  assign output_last  = out_last_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_softmax_stream_p.sv
// Scoreboard bench for softmax_stream_p: rows are generated, expected beats
// queued from an arithmetic reference, and a monitor checks emitted beats.
module tb_softmax_stream_p;

  localparam int LANES = 8;
  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int E_W   = 16;
  localparam int MAXB  = 32;
  localparam int K     = OUT_W + E_W;
  localparam int DW    = LANES * IN_W;
  localparam int OW    = LANES * OUT_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    row_beats;
  logic [DW-1:0] input_bar;
  logic          bar_valid;
  logic          bar_ready;
  logic [OW-1:0] output_bar;
  logic          output_valid;
  logic          output_ready;
  logic          output_last;
  logic          busy;

  softmax_stream_p #(
    .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .E_W(E_W), .MAX_ROW_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .row_beats(row_beats), .input_bar(input_bar),
    .bar_valid(bar_valid), .bar_ready(bar_ready), .output_bar(output_bar),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_last(output_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    lat_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    last_hs_cyc = 0;
  bit    stall_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: e = 2^15 >> (max - x) below 16, S = sum e, R = 2^24 / S
  function automatic longint ref_e(input int d);
    return (d < E_W) ? ((longint'(1) << (E_W - 1)) >> d) : 0;
  endfunction

  task automatic model_push(input logic [DW-1:0] beats[$]);
    int m;
    int x;
    longint s;
    longint r;
    longint p;
    logic [DW-1:0] v;
    beat_t bt;
    m = -128;
    s = 0;
    foreach (beats[b]) begin
      v = beats[b];
      for (int l = 0; l < LANES; l++) begin
        x = int'($signed(v[IN_W*l +: IN_W]));
        if (x > m) m = x;
      end
    end
    foreach (beats[b]) begin
      v = beats[b];
      for (int l = 0; l < LANES; l++) s += ref_e(m - int'($signed(v[IN_W*l +: IN_W])));
    end
    r = (longint'(1) << K) / s;
    foreach (beats[b]) begin
      v = beats[b];
      for (int l = 0; l < LANES; l++) begin
        p = (ref_e(m - int'($signed(v[IN_W*l +: IN_W]))) * r) >> E_W;
        if (p > 255) p = 255;
        bt.data[OUT_W*l +: OUT_W] = 8'(p);
      end
      bt.last = (b == beats.size() - 1);
      exp_q.push_back(bt);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat(input int lo, input int hi);
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++) v[IN_W*l +: IN_W] = 8'(int'($urandom_range(0, hi - lo)) + lo);
    return v;
  endfunction

  task automatic wait_accept();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (bar_ready) begin
        last_hs_cyc = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("input_accept_timeout");
  endtask

  // Drive one row; row_beats is only meaningful on beat 0, so later beats carry junk
  task automatic send_row(input logic [5:0] cfg, input logic [DW-1:0] beats[$],
                          input bit gaps, input bit expect_out);
    foreach (beats[b]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bar_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bar_valid = 1'b1;
      input_bar = beats[b];
      row_beats = (b == 0) ? cfg : 6'($urandom);
      wait_accept();
    end
    bar_valid = 1'b0;
    if (expect_out) begin
      lat_q.push_back(last_hs_cyc + beats.size() + K + 2);
      for (int t = 0; t <= 200; t++) begin
        @(negedge clk);
        if (output_valid) break;
        if (t == 200) fail_now("first_valid_timeout");
        else check("bar_ready_sum_div", 64'(bar_ready), 64'd0);
      end
    end
  endtask

  task automatic rand_row(input logic [5:0] cfg, input int lo, input int hi);
    logic [DW-1:0] beats[$];
    int nb;
    nb = (cfg == 0 || cfg > MAXB) ? MAXB : int'(cfg);
    for (int b = 0; b < nb; b++) beats.push_back(rand_beat(lo, hi));
    model_push(beats);
    send_row(cfg, beats, 1'b1, 1'b1);
  endtask

  task automatic directed_row(input logic [DW-1:0] in_v, input logic [OW-1:0] out_v);
    logic [DW-1:0] beats[$];
    beat_t bt;
    beats.push_back(in_v);
    bt.data = out_v;
    bt.last = 1'b1;
    exp_q.push_back(bt);
    send_row(6'd1, beats, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && (exp_q.size() != 0 || output_valid); t++) @(negedge clk);
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Output-side backpressure
  initial begin
    output_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      output_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: latency of first beat, stability under stall, beat contents
  initial begin
    bit            first_of_row;
    bit            prev_stall;
    logic [OW-1:0] prev_bar;
    logic          prev_last;
    beat_t         eb;
    first_of_row = 1'b1;
    prev_stall   = 1'b0;
    prev_bar     = '0;
    prev_last    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        first_of_row = 1'b1;
        prev_stall   = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(output_valid), 64'd1);
          check("stall_bar", 64'(output_bar), 64'(prev_bar));
          check("stall_last", 64'(output_last), 64'(prev_last));
        end
        prev_stall = 1'b0;
        if (output_valid) begin
          if (first_of_row) begin
            if (lat_q.size() == 0) fail_now("unexpected_output");
            else check("first_valid_cycle", 64'(cyc), 64'(lat_q.pop_front()));
            first_of_row = 1'b0;
          end
          check("bar_ready_out", 64'(bar_ready), 64'd0);
          if (output_ready) begin
            if (exp_q.size() == 0) begin
              fail_now("extra_beat");
            end else begin
              eb = exp_q.pop_front();
              check("output_bar", 64'(output_bar), 64'(eb.data));
              check("output_last", 64'(output_last), 64'(eb.last));
              if (eb.last) first_of_row = 1'b1;
            end
          end else begin
            prev_stall = 1'b1;
            prev_bar   = output_bar;
            prev_last  = output_last;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] beats[$];
    rst       = 1'b1;
    bar_valid = 1'b0;
    row_beats = '0;
    input_bar = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bar_ready", 64'(bar_ready), 64'd1);
    check("rst_output_valid", 64'(output_valid), 64'd0);
    check("rst_output_last", 64'(output_last), 64'd0);
    check("rst_output_bar", 64'(output_bar), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-beat rows with hand-derived results
    directed_row(64'h0000000000000000, 64'h2020202020202020);
    drain();
    directed_row(64'h000000000000000A, 64'h00000000000000FE);
    drain();
    directed_row(64'h808080808080807F, 64'h00000000000000FF);
    drain();

    // Random rows under input gaps and output stalls
    stall_en = 1'b1;
    rand_row(6'd32, -20, 20);
    rand_row(6'd32, -128, 127);
    rand_row(6'($urandom_range(2, 31)), -12, 12);
    rand_row(6'($urandom_range(2, 31)), -128, 127);
    rand_row(6'd0, -20, 20);
    rand_row(6'd40, -20, 20);
    drain();
    stall_en = 1'b0;

    // Reset while dividing a 4-beat row
    for (int b = 0; b < 4; b++) beats.push_back(rand_beat(-30, 30));
    send_row(6'd4, beats, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_output_valid", 64'(output_valid), 64'd0);
    check("mid_rst_bar_ready", 64'(bar_ready), 64'd1);
    @(posedge clk);
    #1;
    directed_row(64'h0000000000000000, 64'h2020202020202020);
    drain();
    repeat (5) @(posedge clk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("latency_queue_empty", 64'(lat_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/softmax_stream_p.md
Name: softmax_stream_p

Overview:
- Parametrised successor of the fixed 64-bit softmax row unit, built as a row-buffered, base-2 integer softmax with ready/valid backpressure on both sides.
- Row length is run-time programmable, up to MAX_ROW_BEATS beats of LANES signed elements each.
- Sits between the QK matmul output stream and the attention·V matmul input in the MHSA datapath.
- Produces normalized unsigned probabilities, one output beat per input beat, in the same order.

Parameters:
- LANES, 8: elements per beat.
- IN_W, 8: signed input element width.
- OUT_W, 8: unsigned output probability width.
- E_W, 16: width of the exp2 intermediate e.
- MAX_ROW_BEATS, 32: row buffer depth in beats.
- Derived, not overridable:
  - N_MAX = LANES*MAX_ROW_BEATS.
  - S_W = E_W + clog2(N_MAX).
  - K = OUT_W + E_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- row_beats  in  clog2(MAX_ROW_BEATS)+1  beats per row; sampled on the first accepted beat of a row.
- input_bar  in  LANES*IN_W  packed signed elements; lane 0 in the LSBs.
- bar_valid  in  1  input beat valid.
- bar_ready  out  1  block can accept an input beat.
- output_bar  out  LANES*OUT_W  packed probabilities; lane 0 in the LSBs.
- output_valid  out  1  output beat valid.
- output_ready  in  1  downstream accepts the output beat.
- output_last  out  1  marks the final beat of the row; qualified by output_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - State goes to IDLE.
  - bar_ready=1, output_valid=0, output_last=0, output_bar=0, busy=0.
  - Beat counters, running max, sum and reciprocal are cleared.
  - Buffer contents are don't-care.
  - Reset mid-row discards the row; no partial output is emitted.
- Handshakes:
  - An input transfer occurs when bar_valid && bar_ready; an output transfer when output_valid && output_ready.
  - output_bar and output_last hold stable while output_valid=1 && output_ready=0.
- Row length N:
  - N = row_beats, latched on the first input handshake.
  - row_beats=0 or row_beats>MAX_ROW_BEATS is clamped to MAX_ROW_BEATS.
- IDLE:
  - bar_ready=1.
  - A handshake stores beat 0, latches N, initialises max to the per-beat max, and goes to LOAD.
  - If N=1, go directly to SUM.
- LOAD:
  - bar_ready=1; each handshake writes the buffer and updates the running signed max M over all elements.
  - On handshake of beat N-1, go to SUM; bar_ready drops the following cycle.
  - bar_valid=0 simply stalls.
- SUM:
  - bar_ready=0; reads one beat per cycle for N cycles.
  - Per element, d = M - x (unsigned, IN_W+1 bits).
  - e = (2^(E_W-1)) >> d when d < E_W, else e = 0.
  - S accumulates all e in S_W bits, with no overflow by construction.
  - S >= 2^(E_W-1) is always true.
- DIV:
  - Sequential restoring divide, R = floor(2^K / S), taking exactly K cycles.
  - R fits in OUT_W+2 bits.
- OUT:
  - Re-reads the buffer beat by beat and recomputes e.
  - Per lane, p = min((e*R) >> E_W, 2^OUT_W - 1).
  - output_valid=1 until N beats have transferred; output_last=1 on beat N-1.
  - After the final output handshake, go to IDLE with bar_ready=1 on the next cycle; the next row's beat 0 may be accepted that cycle.
  - Backpressure stalls OUT only.
- Latency without backpressure: the first output_valid is asserted exactly N+K+2 cycles after the cycle of the last input handshake.
- No input is accepted in SUM, DIV or OUT.
- The buffer is a single bank, so there is no row overlap.

Test Plan:
- Defaults, N=1, all elements 0:
  - Required: e=32768 each, S=2^18, R=64.
  - Output: every lane 0x20, output_last=1 on that beat, first valid 27 cycles after the input handshake.
- Defaults, N=1, lane0=10 and others 0:
  - Required: S=32992, R=508.
  - Output: lane0=254 (0xFE), other lanes 0.
- Defaults, N=1, lane0=127 and others -128:
  - Required: d=255 gives e=0 for lanes 1-7; S=32768, R=512.
  - Output: lane0 saturates from 256 to 255, others 0.
- N=32, random inputs, random bar_valid gaps and random output_ready stalls:
  - Output matches a bit-exact reference model for all 32 beats.
  - output_bar holds stable during stalls.
  - Exactly 32 beats are emitted with output_last only on the 32nd.
  - bar_ready=0 throughout SUM, DIV and OUT.
- row_beats=0 and row_beats=40: both process 32-beat rows; output_last is asserted on beat 31.
- rst asserted while in DIV with 4 beats loaded:
  - Next cycle: busy=0, output_valid=0, bar_ready=1.
  - A following 1-beat all-zero row yields 0x20 in every lane.
